pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-width inter-stage pipeline registers (ID/EX style): one generic stage register carrying a control bundle plus LANES data words.
- Adds a valid/ready handshake, a 2-entry skid buffer so that in_ready is registered, and a flush that inserts a bubble.
- Adds saturating stall and bubble counters.
- Instantiated between any two pipeline stages (ID->EX, EX->MEM, MEM->WB) in place of hand-written registers.

Parameters:
CTRL_W, 9, width of control bundle (EX/MEM/WB control bits concatenated)
DATA_W, 32, width of one data lane
LANES, 3, number of data lanes (e.g. RD1, RD2, SignImm)
CNT_W, 16, width of each performance counter
ZERO_BUBBLE, 1, when 1, out_ctrl reads 0 whenever out_valid=0

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all held entries
in_valid  in  1  upstream entry present
in_ready  out  1  stage can accept (registered)
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  LANES*DATA_W  upstream lanes, lane 0 in LSBs
out_valid  out  1  entry presented downstream
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  presented control bundle
out_data  out  LANES*DATA_W  presented lanes
occupancy  out  2  held entries, 0..2
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1

Behaviour:
- Reset: the one clock is clk; reset is asynchronous and active-low on rst_n. While rst_n=0:
  - state=EMPTY, out_valid=0, in_ready=1, occupancy=0.
  - out_ctrl=0, out_data=0, skid registers=0.
  - stall_cnt=0, bubble_cnt=0.
  - Reset asserted mid-operation discards all entries immediately.
- Transfer definitions: accept = in_valid & in_ready; issue = out_valid & out_ready.
- Registers: main register drives out_*; skid register holds overflow.
- State machine, evaluated only when flush=0:
  - EMPTY: accept -> ONE, main<=in. Otherwise stay.
  - ONE: accept & !issue -> TWO, skid<=in. !accept & issue -> EMPTY. accept & issue -> ONE, main<=in. Neither -> stay, main holds.
  - TWO: in_ready=0, so accept is impossible. issue -> ONE, main<=skid. Otherwise stay, both hold.
- Derived outputs:
  - out_valid=1 in ONE and TWO.
  - in_ready=1 in EMPTY and ONE; it is the registered decode of next state, with no combinational in->out path.
  - occupancy = 0/1/2 for EMPTY/ONE/TWO.
- Latency: an entry accepted in cycle N is presented with out_valid=1 in cycle N+1 when the stage was EMPTY or issuing. Throughput is 1 entry/cycle with out_ready held high.
- Ordering: strict FIFO; the skid entry is never presented before the main entry.
- Flush: highest priority over any handshake in the same cycle.
  - Next state=EMPTY, out_valid=0, in_ready=1.
  - An input offered in the flush cycle is dropped.
  - An issue coinciding with flush counts as delivered (downstream saw valid&ready).
  - Data registers may hold stale values; out_ctrl obeys ZERO_BUBBLE.
- ZERO_BUBBLE=1: out_ctrl is forced to 0 whenever out_valid=0, so downstream sees no write-enables. out_data is unaffected.
- Counters:
  - Increment by 1 per qualifying cycle and saturate at 2^CNT_W-1 (no wrap).
  - Counter qualification uses the current-cycle out_valid/out_ready, independent of flush.
  - Counters are cleared only by rst_n.
- Invalid input: an in_valid=1 offer while in_ready=0 is ignored; upstream must hold it.

Decomposition:
- Shared package pipe_pkg: state encoding constants (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2) and the standard CTRL_W/lane-layout constants per stage boundary.
- One natural sub-module: sat_counter (parameter W; ports clk, rst_n, inc, count), instantiated twice.
- The skid datapath stays inline.

Test Plan:
- Reset: drive rst_n=0 mid-stream with occupancy=2 -> same cycle out_valid=0, in_ready=1, occupancy=0, both counters 0.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with in_data lanes = {i, i+100, i+200} -> out_data matches one cycle later, 8 issues, occupancy never exceeds 1, stall_cnt=0.
- Backpressure: out_ready=0 from cycle 2 while offering A,B,C -> A in main, B in skid, in_ready=0, C held; then out_ready=1 -> A, B, C delivered in order; stall_cnt equals the number of backpressure cycles with out_valid=1.
- Flush in state TWO with in_valid=1 and value D -> next cycle out_valid=0, out_ctrl=0, D never appears, in_ready=1.
- Saturation: CNT_W=3, idle with out_ready=1 for 10 cycles -> bubble_cnt stops at 7.
- Simultaneous events in ONE: accept and issue in the same cycle -> occupancy stays 1, new entry presented next cycle; repeat with flush also high -> EMPTY.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for generic inter-stage pipeline registers.
package pipe_pkg;

  // Stage occupancy states; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Control bundle widths and lane counts at each stage boundary.
  localparam int unsigned ID_EX_CTRL_W  = 9;  // RegWrite..ALUSrc, ALUControl, RegDst
  localparam int unsigned ID_EX_LANES   = 3;  // RD1, RD2, SignImm
  localparam int unsigned EX_MEM_CTRL_W = 5;  // RegWrite, MemtoReg, MemWrite, Branch, Zero
  localparam int unsigned EX_MEM_LANES  = 2;  // ALUOut, WriteData
  localparam int unsigned MEM_WB_CTRL_W = 2;  // RegWrite, MemtoReg
  localparam int unsigned MEM_WB_LANES  = 2;  // ReadData, ALUOut
  localparam int unsigned LANE_W        = 32;

  // Number of held entries for a given state.
  function automatic logic [1:0] occ_of(input state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_TWO:   occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at its maximum value.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, a skid entry
// so in_ready comes straight from a flop, flush-to-bubble, and perf counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W      = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LANES       = 3,
  parameter int unsigned CNT_W       = 16,
  parameter bit          ZERO_BUBBLE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [1:0]              occupancy,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt
);

  localparam int unsigned BUS_W = LANES * DATA_W;

  state_e            state;
  state_e            state_nxt;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [BUS_W-1:0]  skid_data;
  logic              accept;
  logic              issue;
  logic              ld_main_in;
  logic              ld_main_skid;
  logic              ld_skid;

  assign accept = in_valid & in_ready;
  assign issue  = out_valid & out_ready;

  // Next-state and register-load decode; flush overrides every handshake.
  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt  = ST_ONE;
            ld_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          case ({accept, issue})
            2'b10: begin
              state_nxt = ST_TWO;
              ld_skid   = 1'b1;
            end
            2'b01:   state_nxt  = ST_EMPTY;
            2'b11:   ld_main_in = 1'b1;
            default: state_nxt  = ST_ONE;
          endcase
        end
        ST_TWO: begin
          if (issue) begin
            state_nxt    = ST_ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State, handshake flags and datapath registers, all decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
      out_ctrl  <= '0;
      out_data  <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != ST_EMPTY);
      in_ready  <= (state_nxt != ST_TWO);
      occupancy <= occ_of(state_nxt);
      if (ld_main_in) begin
        out_ctrl <= in_ctrl;
        out_data <= in_data;
      end else if (ld_main_skid) begin
        out_ctrl <= skid_ctrl;
        out_data <= skid_data;
      end else if (ZERO_BUBBLE && (state_nxt == ST_EMPTY)) begin
        // Bubbles carry no write-enables downstream; data lanes keep stale values.
        out_ctrl <= '0;
      end
      if (ld_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  // Cycles where downstream holds off a presented entry.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  // Cycles where downstream is ready but nothing is presented.
  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~out_valid & out_ready),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure, flush,
// simultaneous events, async reset with two held entries, counter saturation.
module tb_pipe_stage_skid;

  localparam int unsigned CTRL_W = 9;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 3;
  localparam int unsigned BUS_W  = LANES * DATA_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [BUS_W-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [BUS_W-1:0]  out_data;
  logic [1:0]        occupancy;
  logic [15:0]       stall_cnt;
  logic [15:0]       bubble_cnt;

  // Second instance with narrow counters, kept idle, for saturation.
  logic              in_ready2;
  logic              out_valid2;
  logic              out_ready2;
  logic [CTRL_W-1:0] out_ctrl2;
  logic [BUS_W-1:0]  out_data2;
  logic [1:0]        occupancy2;
  logic [2:0]        stall_cnt2;
  logic [2:0]        bubble_cnt2;

  int nvec = 0;
  int nerr = 0;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .LANES(LANES),
                    .CNT_W(16), .ZERO_BUBBLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .LANES(LANES),
                    .CNT_W(3), .ZERO_BUBBLE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(1'b0), .in_ready(in_ready2), .in_ctrl('0), .in_data('0),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_ctrl(out_ctrl2), .out_data(out_data2),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2)
  );

  function automatic logic [BUS_W-1:0] lanes(input int b);
    return {32'(b + 200), 32'(b + 100), 32'(b)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input int b, input logic [CTRL_W-1:0] c);
    in_valid = v;
    in_data  = lanes(b);
    in_ctrl  = c;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0; out_ready2 = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_occ", 128'(occupancy), 128'(0));
    chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_stall", 128'(stall_cnt), 128'(0));
    chk("rst_bubble", 128'(bubble_cnt), 128'(0));
    rst_n = 1'b1;

    // Streaming at full rate: one empty-and-ready cycle before the first entry
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, i, 9'(i + 1));
      tick();
      chk($sformatf("stream%0d_valid", i), 128'(out_valid), 128'(1));
      chk($sformatf("stream%0d_data", i), 128'(out_data), 128'(lanes(i)));
      chk($sformatf("stream%0d_ctrl", i), 128'(out_ctrl), 128'(i + 1));
      chk($sformatf("stream%0d_occ", i), 128'(occupancy), 128'(1));
    end
    offer(1'b0, 0, '0);
    tick();
    chk("stream_drain_valid", 128'(out_valid), 128'(0));
    chk("stream_drain_ctrl", 128'(out_ctrl), 128'(0));
    chk("stream_stall", 128'(stall_cnt), 128'(0));
    chk("stream_bubble", 128'(bubble_cnt), 128'(1));

    // Backpressure: A to main, B to skid, C held off
    out_ready = 1'b0;
    offer(1'b1, 1000, 9'h0A1);
    tick();
    chk("bp_a_data", 128'(out_data), 128'(lanes(1000)));
    chk("bp_a_occ", 128'(occupancy), 128'(1));
    offer(1'b1, 2000, 9'h0B2);
    tick();
    chk("bp_b_occ", 128'(occupancy), 128'(2));
    chk("bp_b_ready", 128'(in_ready), 128'(0));
    chk("bp_b_main", 128'(out_data), 128'(lanes(1000)));
    offer(1'b1, 3000, 9'h0C3);
    tick();
    tick();
    chk("bp_hold_occ", 128'(occupancy), 128'(2));
    chk("bp_hold_data", 128'(out_data), 128'(lanes(1000)));
    chk("bp_stall3", 128'(stall_cnt), 128'(3));
    out_ready = 1'b1;
    tick();
    chk("bp_deliver_b", 128'(out_data), 128'(lanes(2000)));
    chk("bp_deliver_b_ctrl", 128'(out_ctrl), 128'(9'h0B2));
    chk("bp_deliver_b_ready", 128'(in_ready), 128'(1));
    tick();
    chk("bp_deliver_c", 128'(out_data), 128'(lanes(3000)));
    chk("bp_deliver_c_occ", 128'(occupancy), 128'(1));
    offer(1'b0, 0, '0);
    tick();
    chk("bp_empty_valid", 128'(out_valid), 128'(0));
    chk("bp_stall_final", 128'(stall_cnt), 128'(3));

    // Flush in TWO with D offered
    out_ready = 1'b0;
    offer(1'b1, 5000, 9'h0E5);
    tick();
    offer(1'b1, 6000, 9'h0F6);
    tick();
    chk("fl_two_occ", 128'(occupancy), 128'(2));
    flush = 1'b1;
    offer(1'b1, 4000, 9'h1D4);
    tick();
    chk("fl_valid", 128'(out_valid), 128'(0));
    chk("fl_ctrl", 128'(out_ctrl), 128'(0));
    chk("fl_ready", 128'(in_ready), 128'(1));
    chk("fl_occ", 128'(occupancy), 128'(0));
    chk("fl_stall", 128'(stall_cnt), 128'(5));
    flush = 1'b0;
    offer(1'b0, 0, '0);
    out_ready = 1'b1;
    tick();
    chk("fl_no_d", 128'(out_valid), 128'(0));
    chk("fl_bubble", 128'(bubble_cnt), 128'(2));

    // Accept and issue together in ONE, then again with flush
    offer(1'b1, 7000, 9'h071);
    tick();
    chk("sim_g_data", 128'(out_data), 128'(lanes(7000)));
    offer(1'b1, 8000, 9'h082);
    tick();
    chk("sim_h_occ", 128'(occupancy), 128'(1));
    chk("sim_h_data", 128'(out_data), 128'(lanes(8000)));
    chk("sim_h_ctrl", 128'(out_ctrl), 128'(9'h082));
    flush = 1'b1;
    offer(1'b1, 9000, 9'h093);
    tick();
    chk("simfl_valid", 128'(out_valid), 128'(0));
    chk("simfl_occ", 128'(occupancy), 128'(0));
    chk("simfl_ctrl", 128'(out_ctrl), 128'(0));
    flush = 1'b0;
    offer(1'b0, 0, '0);
    tick();
    chk("simfl_bubble", 128'(bubble_cnt), 128'(4));
    chk("simfl_stall", 128'(stall_cnt), 128'(5));

    // Asynchronous reset with two entries held
    out_ready = 1'b0;
    offer(1'b1, 10000, 9'h0AA);
    tick();
    offer(1'b1, 11000, 9'h0BB);
    tick();
    chk("ar_pre_occ", 128'(occupancy), 128'(2));
    chk("ar_pre_stall", 128'(stall_cnt), 128'(6));
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 128'(out_valid), 128'(0));
    chk("ar_ready", 128'(in_ready), 128'(1));
    chk("ar_occ", 128'(occupancy), 128'(0));
    chk("ar_stall", 128'(stall_cnt), 128'(0));
    chk("ar_bubble", 128'(bubble_cnt), 128'(0));
    offer(1'b0, 0, '0);
    tick();
    rst_n = 1'b1;

    // Saturation on the 3-bit counter instance
    out_ready2 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("sat_bubble5", 128'(bubble_cnt2), 128'(5));
    for (int i = 0; i < 5; i++) tick();
    chk("sat_bubble7", 128'(bubble_cnt2), 128'(7));
    chk("sat_stall0", 128'(stall_cnt2), 128'(0));
    chk("sat_valid", 128'(out_valid2), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
